ex_stage: RTL and testbench

- Execute stage of the single-cycle/pipelined LEGv8 datapath.
- Contains the ALU operand mux, the ALU-control decoder (ALUOp plus instruction opcode), the 64-bit main ALU, and the branch-target adder (pc + (ex_data << 2)).
- Holds a registered NZCV status register that updates only when the control unit asserts SregUp.
- ALUOut and ALU_res are purely combinational.

---
 rtl/ex_stage.sv | 102 ++++++++++
 tb/tb_ex_stage.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// LEGv8 execute stage: operand mux, ALU-control decode, 64-bit ALU, branch-target adder
// and the NZCV status register, which is written only when SregUp is set.
module ex_stage #(
  parameter int WORD      = 64,
  parameter int INST_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WORD-1:0]      r_data1,
  input  logic [WORD-1:0]      r_data2,
  input  logic [WORD-1:0]      ex_data,
  input  logic [INST_SIZE-1:0] inst,
  input  logic [1:0]           ALUOp,
  input  logic                 ALUSrc,
  input  logic                 SregUp,
  input  logic [WORD-1:0]      pc,
  output logic [WORD-1:0]      ALUOut,
  output logic [WORD-1:0]      ALU_res,
  output logic                 N,
  output logic                 Z,
  output logic                 C,
  output logic                 V
);

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_EOR, OP_LSL, OP_LSR, OP_PASSB, OP_NEQ
  } alu_op_e;

  alu_op_e                alu_op;
  logic signed [WORD-1:0] op_a;
  logic signed [WORD-1:0] op_b;
  logic signed [WORD-1:0] b_eff;
  logic        [WORD:0]   sum_ext;
  logic        [5:0]      shamt;
  logic                   is_sub;
  logic                   is_arith;
  logic                   n_n, n_z, n_c, n_v;
  logic        [3:0]      nzcv_d, nzcv_q;

  assign op_a  = r_data1;
  assign op_b  = ALUSrc ? ex_data : r_data2;
  assign shamt = inst[15:10];

  // The branch target is always formed, independent of the ALU class.
  assign ALU_res = pc + (ex_data << 2);

  always_comb begin
    alu_op = OP_ADD;
    unique case (ALUOp)
      2'b00: alu_op = OP_ADD;
      2'b01: alu_op = OP_PASSB;
      2'b11: alu_op = OP_NEQ;
      default: begin
        // S and non-S variants share the datapath; SregUp decides flag writes.
        case (inst[31:21])
          11'h458, 11'h558: alu_op = OP_ADD;
          11'h658, 11'h758: alu_op = OP_SUB;
          11'h450:          alu_op = OP_AND;
          11'h550:          alu_op = OP_ORR;
          11'h650:          alu_op = OP_EOR;
          11'h69B:          alu_op = OP_LSL;
          11'h69A:          alu_op = OP_LSR;
          default:          alu_op = OP_ADD;
        endcase
      end
    endcase
  end

  assign is_sub   = (alu_op == OP_SUB);
  assign is_arith = (alu_op == OP_ADD) || (alu_op == OP_SUB);
  assign b_eff    = is_sub ? ~op_b : op_b;
  assign sum_ext  = {1'b0, op_a} + {1'b0, b_eff} + {{WORD{1'b0}}, is_sub};

  always_comb begin
    ALUOut = sum_ext[WORD-1:0];
    case (alu_op)
      OP_AND:   ALUOut = op_a & op_b;
      OP_ORR:   ALUOut = op_a | op_b;
      OP_EOR:   ALUOut = op_a ^ op_b;
      OP_LSL:   ALUOut = op_a << shamt;
      OP_LSR:   ALUOut = op_a >> shamt;
      OP_PASSB: ALUOut = op_b;
      OP_NEQ:   ALUOut = {{(WORD-1){1'b0}}, (op_a != op_b)};
      default:  ALUOut = sum_ext[WORD-1:0];
    endcase
  end

  assign n_n = ALUOut[WORD-1];
  assign n_z = (ALUOut == '0);
  assign n_c = is_arith & sum_ext[WORD];
  assign n_v = is_arith & (op_a[WORD-1] == b_eff[WORD-1]) & (sum_ext[WORD-1] != op_a[WORD-1]);

  assign nzcv_d = SregUp ? {n_n, n_z, n_c, n_v} : nzcv_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) nzcv_q <= 4'b0000;
    else        nzcv_q <= nzcv_d;
  end

  assign {N, Z, C, V} = nzcv_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: expected results are queued when a step is driven and
// popped when the combinational outputs settle and again after the flag-update edge.
module tb_ex_stage;

  localparam int WORD = 64;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [WORD-1:0] r_data1, r_data2, ex_data, pc;
  logic [31:0]     inst;
  logic [1:0]      ALUOp;
  logic            ALUSrc, SregUp;
  logic [WORD-1:0] ALUOut, ALU_res;
  logic            N, Z, C, V;

  typedef struct {
    string           tag;
    logic [WORD-1:0] alu;
    logic [WORD-1:0] res;
  } comb_exp_t;

  typedef struct {
    string    tag;
    logic [3:0] nzcv;
  } flag_exp_t;

  comb_exp_t comb_q[$];
  flag_exp_t flag_q[$];
  logic [3:0] exp_flags;
  int errors = 0;
  int checks = 0;

  ex_stage #(.WORD(WORD), .INST_SIZE(32)) dut (
    .clk(clk), .rst_n(rst_n), .r_data1(r_data1), .r_data2(r_data2), .ex_data(ex_data),
    .inst(inst), .ALUOp(ALUOp), .ALUSrc(ALUSrc), .SregUp(SregUp), .pc(pc),
    .ALUOut(ALUOut), .ALU_res(ALU_res), .N(N), .Z(Z), .C(C), .V(V)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] rinst(input logic [10:0] opc, input logic [5:0] sh);
    return {opc, 5'd0, sh, 10'd0};
  endfunction

  task automatic chk64(input string tag, input logic [WORD-1:0] obs, input logic [WORD-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed NZCV=%b expected NZCV=%b", tag, obs, exp);
    end
  endtask

  // Drive one instruction; flags are the expected NZCV written if sreg is set.
  task automatic step(input string tag, input logic [WORD-1:0] a, input logic [WORD-1:0] b2,
                      input logic [WORD-1:0] ex, input logic [31:0] in, input logic [1:0] op,
                      input logic src, input logic sreg, input logic [WORD-1:0] p,
                      input logic [WORD-1:0] e_alu, input logic [WORD-1:0] e_res,
                      input logic [3:0] flags);
    comb_exp_t ce;
    flag_exp_t fe;
    @(negedge clk);
    r_data1 = a; r_data2 = b2; ex_data = ex; inst = in; ALUOp = op; ALUSrc = src;
    SregUp = sreg; pc = p;
    ce.tag = tag; ce.alu = e_alu; ce.res = e_res;
    comb_q.push_back(ce);
    if (sreg) exp_flags = flags;
    fe.tag = tag; fe.nzcv = exp_flags;
    flag_q.push_back(fe);
    #1;
    if (comb_q.size() == 0) begin
      checks++; errors++;
      $error("FAIL %s scoreboard empty observed=none expected=entry", tag);
    end else begin
      ce = comb_q.pop_front();
      chk64({ce.tag, "_aluout"}, ALUOut, ce.alu);
      chk64({ce.tag, "_alures"}, ALU_res, ce.res);
    end
    @(posedge clk);
    #1;
    if (flag_q.size() == 0) begin
      checks++; errors++;
      $error("FAIL %s flag scoreboard empty observed=none expected=entry", tag);
    end else begin
      fe = flag_q.pop_front();
      chk4({fe.tag, "_flags"}, {N, Z, C, V}, fe.nzcv);
    end
  endtask

  initial begin
    rst_n = 1'b0; r_data1 = '0; r_data2 = '0; ex_data = '0; inst = '0; ALUOp = 2'b00;
    ALUSrc = 1'b0; SregUp = 1'b1; pc = '0; exp_flags = 4'b0000;
    #12;
    chk4("reset_flags", {N, Z, C, V}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    SregUp = 1'b0;

    step("ldur", 64'd22, 64'd0, 64'd64, 32'h0, 2'b00, 1'b1, 1'b0, 64'd200, 64'd86, 64'd456, 4'b0000);
    step("add", 64'd19, 64'd9, 64'h8B09026A, 32'h8B09026A, 2'b10, 1'b0, 1'b0, 64'd200,
         64'd28, 64'h22C240A70, 4'b0000);
    step("sub", 64'd20, 64'd20, 64'hCB0A028B, 32'hCB0A028B, 2'b10, 1'b0, 1'b0, 64'd200,
         64'd0, 64'h32C280AF4, 4'b0000);
    step("stur", 64'd22, 64'd0, 64'd96, 32'h0, 2'b00, 1'b1, 1'b0, 64'd200, 64'd118, 64'd584, 4'b0000);
    step("cbz", 64'd27, 64'd0, 64'hFFFFFFFFFFFFFFFB, 32'h0, 2'b01, 1'b1, 1'b1, 64'd200,
         64'hFFFFFFFFFFFFFFFB, 64'd180, 4'b1000);
    step("cbnz", 64'd27, 64'd0, 64'd8, 32'h0, 2'b01, 1'b1, 1'b0, 64'd200, 64'd8, 64'hE8, 4'b1000);
    step("b", 64'd2, 64'd0, 64'd64, 32'h0, 2'b11, 1'b0, 1'b0, 64'd200, 64'd1, 64'd456, 4'b1000);
    step("neq_eq", 64'd7, 64'd7, 64'd0, 32'h0, 2'b11, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0, 4'b1000);
    step("subs_eq", 64'd5, 64'd5, 64'd3, rinst(11'h758, 6'd0), 2'b10, 1'b0, 1'b1, 64'd200,
         64'd0, 64'd212, 4'b0110);
    step("hold", 64'd3, 64'd5, 64'd3, rinst(11'h758, 6'd0), 2'b10, 1'b0, 1'b0, 64'd200,
         64'hFFFFFFFFFFFFFFFE, 64'd212, 4'b0110);
    step("subs_borrow", 64'd3, 64'd5, 64'd3, rinst(11'h758, 6'd0), 2'b10, 1'b0, 1'b1, 64'd200,
         64'hFFFFFFFFFFFFFFFE, 64'd212, 4'b1000);
    step("adds_ovf", 64'h7FFFFFFFFFFFFFFF, 64'd1, 64'd3, rinst(11'h558, 6'd0), 2'b10, 1'b0, 1'b1,
         64'd200, 64'h8000000000000000, 64'd212, 4'b1001);
    step("adds_carry", 64'hFFFFFFFFFFFFFFFF, 64'd1, 64'd3, rinst(11'h558, 6'd0), 2'b10, 1'b0, 1'b1,
         64'd200, 64'd0, 64'd212, 4'b0110);
    step("subs_vneg", 64'h8000000000000000, 64'd1, 64'd3, rinst(11'h758, 6'd0), 2'b10, 1'b0, 1'b1,
         64'd200, 64'h7FFFFFFFFFFFFFFF, 64'd212, 4'b0011);
    step("and_flags", 64'hF0F0, 64'h0F0F, 64'd0, rinst(11'h450, 6'd0), 2'b10, 1'b0, 1'b1, 64'd8,
         64'd0, 64'd8, 4'b0100);
    step("and", 64'hF0F0, 64'hFF00, 64'd0, rinst(11'h450, 6'd0), 2'b10, 1'b0, 1'b0, 64'd8,
         64'hF000, 64'd8, 4'b0100);
    step("orr", 64'hF0F0, 64'hFF00, 64'd0, rinst(11'h550, 6'd0), 2'b10, 1'b0, 1'b0, 64'd8,
         64'hFFF0, 64'd8, 4'b0100);
    step("eor", 64'hF0F0, 64'hFF00, 64'd0, rinst(11'h650, 6'd0), 2'b10, 1'b0, 1'b0, 64'd8,
         64'h0FF0, 64'd8, 4'b0100);
    step("lsl", 64'd1, 64'd0, 64'd0, rinst(11'h69B, 6'd63), 2'b10, 1'b0, 1'b1, 64'd8,
         64'h8000000000000000, 64'd8, 4'b1000);
    step("lsr", 64'h8000000000000000, 64'd0, 64'd0, rinst(11'h69A, 6'd4), 2'b10, 1'b0, 1'b0, 64'd8,
         64'h0800000000000000, 64'd8, 4'b1000);
    step("rtype_default", 64'd100, 64'd23, 64'd0, rinst(11'h7FF, 6'd0), 2'b10, 1'b0, 1'b0, 64'd8,
         64'd123, 64'd8, 4'b1000);
    step("branch_wrap", 64'd0, 64'd0, 64'h4000000000000001, 32'h0, 2'b01, 1'b1, 1'b0,
         64'hFFFFFFFFFFFFFFFC, 64'h4000000000000001, 64'd0, 4'b1000);

    // Asynchronous reset between edges: flags clear at once, datapath keeps following inputs.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk4("async_reset_flags", {N, Z, C, V}, 4'b0000);
    chk64("reset_aluout_live", ALUOut, 64'h4000000000000001);
    #1;
    rst_n = 1'b1;
    exp_flags = 4'b0000;
    step("post_reset_hold", 64'd1, 64'd2, 64'd1, 32'h0, 2'b00, 1'b0, 1'b0, 64'd0, 64'd3, 64'd4, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
